fsquare_seq: RTL and testbench

- Multi-cycle single-precision squarer: y = x*x. This is the inverse operation of the FPU's combinational fsqrt.
- Used by the FPU's verification and reference-check path. A later iteration-refinement unit also uses it to square candidate roots.
- Iterative shift-add mantissa multiply, one multiplier bit per cycle.
- Valid/ready handshake on both input and output. One operation in flight.

---
 rtl/fsquare_seq.sv | 145 ++++++++++++++
 tb/tb_fsquare_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fsquare_seq.sv
// rtl/fsquare_seq.sv - multi-cycle single-precision squarer, y = x*x
// Shift-add mantissa multiply (one multiplier bit per cycle), valid/ready on both sides.
module fsquare_seq #(
  parameter int MANT_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        exception,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic        special_q, special_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] y_q, y_d;
  logic        exc_q, exc_d;
  logic        out_valid_q, out_valid_d;

  logic               p_hi, guard, sticky, inc;
  logic [22:0]        frac;
  logic [23:0]        frac_rnd;
  logic signed [10:0] er, er_rnd;
  logic [31:0]        res_y;
  logic               res_exc;

  // Normalise, round-to-nearest-even and range-check the finished product.
  always_comb begin
    p_hi     = acc_q[47];
    frac     = p_hi ? acc_q[46:24] : acc_q[45:23];
    guard    = p_hi ? acc_q[23] : acc_q[22];
    sticky   = p_hi ? (|acc_q[22:0]) : (|acc_q[21:0]);
    er       = $signed({2'b00, x_q[30:23], 1'b0}) - 11'sd127 + (p_hi ? 11'sd1 : 11'sd0);
    inc      = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + {23'd0, inc};
    er_rnd   = er + (frac_rnd[23] ? 11'sd1 : 11'sd0);
    res_y    = 32'h0000_0000;
    res_exc  = 1'b0;
    if (special_q) begin
      if (x_q[30:23] == 8'hFF) begin
        if (x_q[22:0] != 23'd0) begin
          res_y   = {x_q[31], 8'hFF, 1'b1, x_q[21:0]};
          res_exc = 1'b1;
        end else begin
          res_y = 32'h7F80_0000;
        end
      end
    end else if (er <= 11'sd0) begin
      res_y = 32'h0000_0000;
    end else if (er_rnd >= 11'sd255) begin
      res_y   = 32'h7F80_0000;
      res_exc = 1'b1;
    end else begin
      res_y = {1'b0, er_rnd[7:0], frac_rnd[22:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    special_d   = special_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    exc_d       = exc_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = x;
          special_d = (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
          mcand_d   = {24'd0, 1'b1, x[22:0]};
          mplier_d  = {1'b1, x[22:0]};
          acc_d     = 48'd0;
          cnt_d     = 5'd0;
          state_d   = special_d ? ROUND : MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[46:0], 1'b0};
        mplier_d = {1'b0, mplier_q[23:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(MANT_W - 1)) state_d = ROUND;
      end
      ROUND: begin
        y_d         = res_y;
        exc_d       = res_exc;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= 32'd0;
      special_q   <= 1'b0;
      mcand_q     <= 48'd0;
      mplier_q    <= 24'd0;
      acc_q       <= 48'd0;
      cnt_q       <= 5'd0;
      y_q         <= 32'd0;
      exc_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      special_q   <= special_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      exc_q       <= exc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign y         = y_q;
  assign exception = exc_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fsquare_seq.sv
// tb/tb_fsquare_seq.sv - directed self-checking bench for fsquare_seq
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fsquare_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        exception;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  fsquare_seq #(.MANT_W(24)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .exception(exception), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] xin, input logic [31:0] ey,
                        input logic eexc, input int elat, input logic pre_rdy, input int hold);
    int          lat;
    logic        rdy_seen;
    logic        stable;
    logic [31:0] y0;
    logic        e0;
    out_ready = pre_rdy;
    x         = xin;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    x         = 32'hDEAD_BEEF;
    lat       = 0;
    rdy_seen  = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    rdy_seen |= in_ready;
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_y"}, y, ey);
    check({tag, "_exc"}, {31'd0, exception}, {31'd0, eexc});
    check({tag, "_busy"}, {31'd0, rdy_seen}, 32'd0);
    if (!pre_rdy) begin
      y0     = y;
      e0     = exception;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (y !== y0 || exception !== e0 || out_valid !== 1'b1) stable = 1'b0;
      end
      if (hold > 0) check({tag, "_hold"}, {31'd0, stable}, 32'd1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int   acc_n;
    int   hs_n;
    logic rdy_b;
    logic ov_b;
    logic iv_b;
    rst       = 1'b1;
    x         = 32'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_y", y, 32'd0);
    check("rst_exc", {31'd0, exception}, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("three",   32'h4040_0000, 32'h4110_0000, 1'b0, 25, 1'b1, 0);
    run_op("neg2",    32'hC000_0000, 32'h4080_0000, 1'b0, 25, 1'b0, 0);
    run_op("sticky",  32'h3F80_0001, 32'h3F80_0002, 1'b0, 25, 1'b0, 0);
    run_op("onehalf", 32'h3FC0_0000, 32'h4010_0000, 1'b0, 25, 1'b0, 0);
    run_op("emax",    32'h5F00_0000, 32'h7E80_0000, 1'b0, 25, 1'b0, 0);
    run_op("ovf",     32'h5F80_0000, 32'h7F80_0000, 1'b1, 25, 1'b0, 0);
    run_op("uflow",   32'h1F80_0000, 32'h0000_0000, 1'b0, 25, 1'b0, 0);
    run_op("nan",     32'h7FC0_0001, 32'h7FC0_0001, 1'b1, 1, 1'b0, 0);
    run_op("ninf",    32'hFF80_0000, 32'h7F80_0000, 1'b0, 1, 1'b0, 0);
    run_op("subn",    32'h0000_0001, 32'h0000_0000, 1'b0, 1, 1'b0, 0);
    run_op("nzero",   32'h8000_0000, 32'h0000_0000, 1'b0, 1, 1'b0, 0);
    run_op("bp",      32'h4040_0000, 32'h4110_0000, 1'b0, 25, 1'b0, 10);

    // Abort mid-multiply; y still holds the previous 9.0 result at this point.
    x        = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_y", y, 32'd0);
    check("arst_ov", {31'd0, out_valid}, 32'd0);
    check("arst_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    run_op("after_rst", 32'h4040_0000, 32'h4110_0000, 1'b0, 25, 1'b0, 0);

    // Continuous in_valid with a latency-1 operand: accept on edges 1,4,...,40.
    acc_n     = 0;
    hs_n      = 0;
    x         = 32'hFF80_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 40) in_valid = 1'b0;
      rdy_b = in_ready;
      ov_b  = out_valid;
      iv_b  = in_valid;
      @(posedge clk); #1;
      if (rdy_b && iv_b) acc_n++;
      if (ov_b) hs_n++;
    end
    out_ready = 1'b0;
    check("b2b_accepts", 32'(acc_n), 32'd14);
    check("b2b_handshakes", 32'(hs_n), 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
